// File: rtl/spi_cmd_scheduler_if.sv
// Requester handshake plus SPI driver command bus for spi_cmd_scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface spi_cmd_scheduler_if #(
  parameter int REG_WIDTH = 8
);
  // Requester side; bit i / slice i belongs to requester i.
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_is_write;
  logic [2*REG_WIDTH-1:0] req_addr;
  logic [2*REG_WIDTH-1:0] req_wdata;
  logic [15:0]            req_num_regs;
  logic                   done;
  logic                   done_id;
  logic                   done_err;
  logic                   busy;

  // SPI driver side.
  logic                   new_command;
  logic                   is_write;
  logic [REG_WIDTH-1:0]   write_register_addr;
  logic [REG_WIDTH-1:0]   write_data;
  logic [7:0]             start_read_register_addr;
  logic [7:0]             num_regs_to_read;
  logic                   write_complete;
  logic                   read_complete;

  modport slave (
    input  req_valid, req_is_write, req_addr, req_wdata, req_num_regs,
    input  write_complete, read_complete,
    output req_ready, done, done_id, done_err, busy,
    output new_command, is_write, write_register_addr, write_data,
    output start_read_register_addr, num_regs_to_read
  );

  modport master (
    output req_valid, req_is_write, req_addr, req_wdata, req_num_regs,
    output write_complete, read_complete,
    input  req_ready, done, done_id, done_err, busy,
    input  new_command, is_write, write_register_addr, write_data,
    input  start_read_register_addr, num_regs_to_read
  );
endinterface

// File: rtl/spi_cmd_scheduler.sv
// Two-requester round-robin scheduler that sequences one command at a time onto
// the SPI driver, with per-command completion/timeout reporting.
module spi_cmd_scheduler #(
  parameter int REG_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 13
) (
  input  logic                    clk,
  input  logic                    rstn,
  spi_cmd_scheduler_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   last_grant_q;
  logic                   owner_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;

  logic                   new_command_q;
  logic                   done_q;
  logic                   done_id_q;
  logic                   done_err_q;
  logic                   busy_q;
  logic                   is_write_q;
  logic [REG_WIDTH-1:0]   write_register_addr_q;
  logic [REG_WIDTH-1:0]   write_data_q;
  logic [7:0]             start_read_register_addr_q;
  logic [7:0]             num_regs_to_read_q;

  logic [REG_WIDTH-1:0]   req_addr_a  [2];
  logic [REG_WIDTH-1:0]   req_wdata_a [2];
  logic [7:0]             req_nregs_a [2];

  logic                   grant_valid;
  logic                   grant_id;
  logic                   grant_zero_len;
  logic                   complete_match;
  logic                   timeout_hit;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign req_addr_a[gi]  = bus.req_addr[gi*REG_WIDTH +: REG_WIDTH];
      assign req_wdata_a[gi] = bus.req_wdata[gi*REG_WIDTH +: REG_WIDTH];
      assign req_nregs_a[gi] = bus.req_num_regs[gi*8 +: 8];
    end
  endgenerate

  // Round-robin grant: a lone requester always wins, on contention the one
  // that did not win last time goes next.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == IDLE) begin
      case (bus.req_valid)
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant_id    = ~last_grant_q;
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = {grant_valid & grant_id, grant_valid & ~grant_id};

  // A zero-length read has nothing to send, so it completes without the driver.
  assign grant_zero_len = ~bus.req_is_write[grant_id] && (req_nregs_a[grant_id] == 8'd0);

  // Only the completion matching the latched direction counts.
  assign complete_match = is_write_q ? bus.write_complete : bus.read_complete;
  assign cnt_d          = cnt_q + 1'b1;
  assign timeout_hit    = (cnt_d == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q                    <= IDLE;
      last_grant_q               <= 1'b1;
      owner_q                    <= 1'b0;
      cnt_q                      <= '0;
      new_command_q              <= 1'b0;
      done_q                     <= 1'b0;
      done_id_q                  <= 1'b0;
      done_err_q                 <= 1'b0;
      busy_q                     <= 1'b0;
      is_write_q                 <= 1'b0;
      write_register_addr_q      <= '0;
      write_data_q               <= '0;
      start_read_register_addr_q <= '0;
      num_regs_to_read_q         <= '0;
    end else begin
      new_command_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q                    <= grant_id;
            last_grant_q               <= grant_id;
            busy_q                     <= 1'b1;
            is_write_q                 <= bus.req_is_write[grant_id];
            write_register_addr_q      <= req_addr_a[grant_id];
            write_data_q               <= req_wdata_a[grant_id];
            start_read_register_addr_q <= 8'(req_addr_a[grant_id]);
            num_regs_to_read_q         <= req_nregs_a[grant_id];
            if (grant_zero_len) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              done_id_q  <= grant_id;
              done_err_q <= 1'b0;
            end else begin
              state_q       <= ISSUE;
              new_command_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          // A completion on the final cycle beats the timeout.
          if (complete_match || timeout_hit) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            done_id_q  <= owner_q;
            done_err_q <= ~complete_match;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          done_id_q  <= 1'b0;
          done_err_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.new_command              = new_command_q;
  assign bus.done                     = done_q;
  assign bus.done_id                  = done_id_q;
  assign bus.done_err                 = done_err_q;
  assign bus.busy                     = busy_q;
  assign bus.is_write                 = is_write_q;
  assign bus.write_register_addr      = write_register_addr_q;
  assign bus.write_data               = write_data_q;
  assign bus.start_read_register_addr = start_read_register_addr_q;
  assign bus.num_regs_to_read         = num_regs_to_read_q;

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(bus.req_ready));
  a_pulse_exclusive : assert property (@(posedge clk) disable iff (!rstn)
    !(bus.new_command && bus.done));

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Randomised scoreboard bench for spi_cmd_scheduler with directed corner cases.
module tb_spi_cmd_scheduler;

  localparam int RW      = 8;
  localparam int TIMEOUT = 16;

  typedef struct {
    int         cyc;
    logic [1:0] ready;
  } grant_t;

  typedef struct {
    int       cyc;
    logic     w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] nregs;
  } cmd_t;

  typedef struct {
    int       cyc;
    logic     id;
    logic     err;
    logic     w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] nregs;
  } done_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   n_done;
  int   busy_lo;
  int   busy_hi;
  logic model_last;

  grant_t grant_q[$];
  cmd_t   cmd_q[$];
  done_t  done_q[$];

  spi_cmd_scheduler_if #(.REG_WIDTH(RW)) bus ();

  spi_cmd_scheduler #(
    .REG_WIDTH     (RW),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_WIDTH     (5)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: one command at a time, round-robin on contention,
  // done one cycle after a matching completion inside the WAIT window, or
  // TIMEOUT cycles after new_command when no such completion arrives.
  task automatic do_txn(input logic [1:0] pat, input bit hold, input logic [1:0] wr,
                        input logic [15:0] ad, input logic [15:0] wd, input logic [15:0] nr,
                        input int comp_off, input bit strays, input int abort_off);
    int   a, e, m, gi;
    logic g, w, err, zl;
    logic [7:0] f_addr, f_wdata, f_nregs;
    bit   mp, op;
    a = cyc;
    bus.req_valid    = pat;
    bus.req_is_write = wr;
    bus.req_addr     = ad;
    bus.req_wdata    = wd;
    bus.req_num_regs = nr;
    if (pat == 2'b01)      g = 1'b0;
    else if (pat == 2'b10) g = 1'b1;
    else                   g = ~model_last;
    model_last = g;
    gi      = int'(g);
    w       = wr[gi];
    f_addr  = ad[gi*8 +: 8];
    f_wdata = wd[gi*8 +: 8];
    f_nregs = nr[gi*8 +: 8];
    zl      = !w && (f_nregs == 8'd0);
    m       = (comp_off >= 1) ? a + 1 + comp_off : -100;
    grant_q.push_back('{a, g ? 2'b10 : 2'b01});
    if (zl) begin
      e   = a + 1;
      err = 1'b0;
    end else begin
      cmd_q.push_back('{a + 1, w, f_addr, f_wdata, f_nregs});
      if (comp_off >= 1 && m <= a + TIMEOUT) begin
        e   = m + 1;
        err = 1'b0;
      end else begin
        e   = a + TIMEOUT + 1;
        err = 1'b1;
      end
    end
    done_q.push_back('{e, g, err, w, f_addr, f_wdata, f_nregs});
    busy_lo = a + 1;
    busy_hi = e;
    next_cycle();
    if (!hold) bus.req_valid = 2'b00;
    while (cyc <= e) begin
      if (abort_off > 0 && cyc == a + abort_off) begin
        rstn = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_new_command", bus.new_command, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_wr_addr", bus.write_register_addr, 8'h00);
        grant_q.delete();
        cmd_q.delete();
        done_q.delete();
        model_last = 1'b1;
        busy_lo = 1;
        busy_hi = 0;
        bus.req_valid      = 2'b00;
        bus.write_complete = 1'b0;
        bus.read_complete  = 1'b0;
        next_cycle();
        next_cycle();
        rstn = 1'b1;
        next_cycle();
        return;
      end
      mp = (cyc == m) || (strays && (cyc == a + 1 || cyc == e));
      op = strays && ($urandom_range(0, 1) == 1);
      bus.write_complete = w ? mp : op;
      bus.read_complete  = w ? op : mp;
      next_cycle();
    end
    bus.write_complete = 1'b0;
    bus.read_complete  = 1'b0;
    if (hold) bus.req_valid = 2'b00;
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin : monitor
    grant_t gx;
    cmd_t   cx;
    done_t  dx;
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi));
        if (bus.req_ready != 2'b00) begin
          if (grant_q.size() == 0) unexpected("req_ready", bus.req_ready);
          else begin
            gx = grant_q.pop_front();
            chk("grant_cycle", cyc, gx.cyc);
            chk("grant", bus.req_ready, gx.ready);
          end
        end
        if (bus.new_command) begin
          if (cmd_q.size() == 0) unexpected("new_command", bus.new_command);
          else begin
            cx = cmd_q.pop_front();
            chk("cmd_cycle", cyc, cx.cyc);
            chk("cmd_is_write", bus.is_write, cx.w);
            chk("cmd_wr_addr", bus.write_register_addr, cx.addr);
            chk("cmd_wdata", bus.write_data, cx.wdata);
            chk("cmd_rd_addr", bus.start_read_register_addr, cx.addr);
            chk("cmd_nregs", bus.num_regs_to_read, cx.nregs);
          end
        end
        if (bus.done) begin
          if (done_q.size() == 0) unexpected("done", bus.done);
          else begin
            dx = done_q.pop_front();
            n_done++;
            $display("txn %0d: done id=%0d err=%0d cycle=%0d (expected id=%0d err=%0d cycle=%0d)",
                     n_done, bus.done_id, bus.done_err, cyc, dx.id, dx.err, dx.cyc);
            chk("done_cycle", cyc, dx.cyc);
            chk("done_id", bus.done_id, dx.id);
            chk("done_err", bus.done_err, dx.err);
            chk("hold_is_write", bus.is_write, dx.w);
            chk("hold_wr_addr", bus.write_register_addr, dx.addr);
            chk("hold_wdata", bus.write_data, dx.wdata);
            chk("hold_nregs", bus.num_regs_to_read, dx.nregs);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int   co;
    logic [15:0] nr;
    cyc        = 0;
    n_checks   = 0;
    n_pass     = 0;
    n_done     = 0;
    busy_lo    = 1;
    busy_hi    = 0;
    model_last = 1'b1;
    rstn       = 1'b0;
    bus.req_valid      = 2'b00;
    bus.req_is_write   = 2'b00;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.req_num_regs   = '0;
    bus.write_complete = 1'b0;
    bus.read_complete  = 1'b0;
    repeat (3) next_cycle();

    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_new_command", bus.new_command, 1'b0);
    chk("reset_is_write", bus.is_write, 1'b0);
    chk("reset_wr_addr", bus.write_register_addr, 8'h00);
    chk("reset_nregs", bus.num_regs_to_read, 8'h00);
    chk("reset_ready", bus.req_ready, 2'b00);
    rstn = 1'b1;
    next_cycle();

    // Single write from requester 0, completed 10 cycles after new_command.
    do_txn(2'b01, 1'b0, 2'b01, 16'h0012, 16'h00A5, 16'h0000, 10, 1'b0, 0);
    // Zero-length read from requester 1.
    do_txn(2'b10, 1'b0, 2'b00, 16'h3300, 16'h0000, 16'h0005, -1, 1'b1, 0);
    // Timeout on a 4-register read with stray write completions.
    do_txn(2'b01, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h0004, -1, 1'b1, 0);
    // Completion on the last counted cycle beats the timeout.
    do_txn(2'b01, 1'b0, 2'b00, 16'h0041, 16'h0000, 16'h0004, TIMEOUT - 1, 1'b0, 0);
    // Reset while waiting, then contention straight after reset.
    do_txn(2'b10, 1'b0, 2'b10, 16'h5500, 16'h6600, 16'h0000, -1, 1'b0, 5);
    for (int i = 0; i < 4; i++)
      do_txn(2'b11, 1'b1, 2'b11, 16'h2010 + 16'(i), 16'h7080, 16'h0101, 5, 1'b0, 0);

    for (int i = 0; i < 50; i++) begin
      nr[7:0]  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      nr[15:8] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      case ($urandom_range(0, 7))
        0:       co = -1;
        1:       co = TIMEOUT - 1;
        2:       co = 0;
        default: co = $urandom_range(1, TIMEOUT - 2);
      endcase
      do_txn(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             16'($urandom), 16'($urandom), nr, co, 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) next_cycle();
    chk("grant_q_left", grant_q.size(), 0);
    chk("cmd_q_left", cmd_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
